// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
//   CLK     system clock, rising edge
//   RESETN  asynchronous active-low reset
//   START   request strobe, sampled only in IDLE
//   FUNCT   00 DIV, 01 DIVU, 10 REM, 11 REMU
//   DATA1   dividend
//   DATA2   divisor
//   FLUSH   aborts any in-flight operation or a START in the same cycle
//   RESULT  registered quotient/remainder, held until the next VALID
//   BUSY    high while an accepted request is in flight
//   VALID   one-cycle pulse marking a new RESULT
module iter_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  START,
    input  logic [1:0]            FUNCT,
    input  logic [DATA_WIDTH-1:0] DATA1,
    input  logic [DATA_WIDTH-1:0] DATA2,
    input  logic                  FLUSH,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  BUSY,
    output logic                  VALID
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  rem, quo, dvsr;
    logic          op_rem, qsign, rsign;

    logic          is_signed, sign1, sign2, div_zero, ovf;
    logic [W-1:0]  mag1, mag2, q_fix, r_fix;
    logic [W:0]    rem_sh, diff;

    always_comb begin
        is_signed = ~FUNCT[0];
        sign1     = is_signed & DATA1[W-1];
        sign2     = is_signed & DATA2[W-1];
        mag1      = sign1 ? -DATA1 : DATA1;
        mag2      = sign2 ? -DATA2 : DATA2;
        div_zero  = DATA2 == '0;
        ovf       = is_signed & (DATA1 == MIN_NEG) & (DATA2 == '1);
        rem_sh    = {rem, quo[W-1]};
        // rem_sh < 2*dvsr, so W+1 bits hold the trial difference with a valid sign bit
        diff      = rem_sh - {1'b0, dvsr};
        q_fix     = qsign ? -quo : quo;
        r_fix     = rsign ? -rem : rem;
    end

    assign BUSY = state != S_IDLE;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
            op_rem <= 1'b0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            RESULT <= '0;
            VALID  <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (state)
                S_IDLE: if (START && !FLUSH) begin
                    op_rem <= FUNCT[1];
                    dvsr   <= mag2;
                    rsign  <= sign1;
                    // Fast paths preload DONE so the common sign fixup yields the RISC-V results
                    if (div_zero) begin
                        quo   <= '1;
                        rem   <= mag1;
                        qsign <= 1'b0;
                        state <= S_DONE;
                    end else if (ovf) begin
                        quo   <= MIN_NEG;
                        rem   <= '0;
                        qsign <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        quo   <= mag1;
                        rem   <= '0;
                        qsign <= sign1 ^ sign2;
                        cnt   <= CW'(W);
                        state <= S_CALC;
                    end
                end
                S_CALC: if (FLUSH) begin
                    state <= S_IDLE;
                end else begin
                    rem   <= diff[W] ? rem_sh[W-1:0] : diff[W-1:0];
                    quo   <= {quo[W-2:0], ~diff[W]};
                    cnt   <= cnt - 1'b1;
                    state <= cnt == CW'(1) ? S_DONE : S_CALC;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (!FLUSH) begin
                        RESULT <= op_rem ? r_fix : q_fix;
                        VALID  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Sits beside the combinational execute-stage ALU. The ALU hands divide operations to this block and stalls the pipeline on BUSY until VALID.
- Takes operands through a start/busy/valid handshake and returns one registered 32-bit result per accepted request.
- Division-by-zero and signed-overflow results follow the RISC-V specification.

Parameters:
- DATA_WIDTH, 32, operand and result width; iteration count equals DATA_WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- START  input  1  request strobe; sampled only in IDLE.
- FUNCT  input  2  operation select: 00 DIV (signed quotient), 01 DIVU, 10 REM (signed remainder), 11 REMU.
- DATA1  input  DATA_WIDTH  dividend.
- DATA2  input  DATA_WIDTH  divisor.
- FLUSH  input  1  pipeline flush; aborts any in-flight operation.
- RESULT  output  DATA_WIDTH  quotient or remainder; registered; holds its value until the next VALID.
- BUSY  output  1  high from the edge that accepts START until the edge that raises VALID or aborts on FLUSH.
- VALID  output  1  single-cycle pulse; RESULT is valid while VALID is high.

Behaviour:
- Reset (RESETN low, asynchronous): state IDLE; RESULT=0, BUSY=0, VALID=0; counter, partial remainder, quotient and latched FUNCT/sign flags all cleared. Reset mid-operation discards the operation and produces no VALID.
- State machine: IDLE, CALC, DONE.
- IDLE
  - VALID=0 in every cycle except the cycle immediately following a DONE edge or a fast-path edge.
  - START=1 and FLUSH=0 at edge N:
    - Latch FUNCT.
    - Signed ops: latch the absolute values of DATA1/DATA2, the dividend sign, and the quotient sign (sign1 XOR sign2).
    - Unsigned ops: latch operands unchanged and treat both signs as 0.
    - Set BUSY=1.
  - Fast path at edge N (no CALC):
    - Divisor == 0: quotient = all ones (0xFFFFFFFF); remainder = DATA1 unchanged. Applies to signed and unsigned ops.
    - Signed op with DATA1 = 0x80000000 and DATA2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
    - Fast-path result is written to RESULT with VALID=1 at edge N+1. BUSY is high for the cycle between edges N and N+1; the state returns to IDLE at N+1.
  - Otherwise go to CALC with counter = DATA_WIDTH.
- CALC
  - One iteration per edge: shift {rem, quo} left by 1, trial-subtract the divisor magnitude from rem, keep the result when non-negative, and set quo[0] accordingly. Decrement the counter.
  - After DATA_WIDTH iterations (edges N+1 .. N+32) go to DONE.
- DONE
  - Apply sign fixup: negate the quotient when the quotient sign is set; negate the remainder when the dividend sign is set (remainder takes the dividend's sign).
  - Select quotient or remainder by FUNCT[1] and register RESULT.
  - VALID=1 and BUSY=0 at edge N+33; return to IDLE.
  - Total latency from START to VALID: 33 cycles normal, 1 cycle fast path.
- Back-to-back: START is accepted in the IDLE cycle in which VALID is high, so the next request may start one cycle after the previous result. Maximum throughput is one result per 34 cycles.
- START while BUSY: ignored; operands are not re-latched.
- FLUSH:
  - In CALC or DONE: next edge returns to IDLE with BUSY=0 and VALID=0; RESULT keeps its previous value.
  - FLUSH together with START in IDLE: the request is dropped.
  - FLUSH high on the edge that would raise VALID: VALID is suppressed and RESULT is not updated.
- Operand inputs may change freely after the accepting edge; only latched copies are used.
- Arithmetic: internal remainder is DATA_WIDTH+1 bits wide for the trial subtraction. Negation is two's complement. The magnitude of 0x80000000 is 0x80000000 treated as unsigned.

Test Plan:
- DIV 100 / -7 (DATA1=0x64, DATA2=0xFFFFFFF9) → VALID exactly 33 cycles after START, RESULT=0xFFFFFFF2 (-14); REM same operands → 0x00000002.
- DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF; REMU → 1; BUSY high for 33 cycles, VALID a single one-cycle pulse.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF, REM -5/0 → 0xFFFFFFFB; each with VALID one cycle after START.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; both one-cycle latency.
- FLUSH asserted at iteration 10 of a DIVU → BUSY drops next edge, no VALID, RESULT unchanged; START one cycle later (DIVU 9/3) → 3 after 33 cycles.
- START pulsed repeatedly while BUSY with different operands → only the first request completes with the correct result. RESETN pulled low mid-CALC → all outputs 0 immediately, no VALID after release.
